score_display_driver: RTL and testbench

Consumes the 8-bit `SCORE` and 2-bit digit `STROBE` produced by the score counter and drives the four-digit, common-anode seven-segment display. A sequential double-dabble FSM converts the binary score to three BCD digits. The strobe then time-multiplexes those digits onto shared, active-low segment lines. The block sits between the score counter and the board display pins.

---
 rtl/score_disp_pkg.sv | 38 +++
 rtl/seg7_decoder.sv | 31 +++
 rtl/score_display_driver.sv | 150 +++++++++++++++
 tb/tb_score_display_driver.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_disp_pkg.sv
// Shared constants and types for the score display driver: active-low
// seven-segment codes, anode enable patterns, FSM state encoding and the
// double-dabble nibble adjust.
package score_disp_pkg;

  // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}; dp always off
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low anode enables; bit n drives digit n
  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;
  localparam logic [3:0] AN_NONE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // Double-dabble correction: a BCD nibble of 5 or more would overflow past
  // 9 when doubled, so pre-add 3 to carry correctly into the next nibble.
  function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder with a blank
// override. Non-decimal codes decode to all segments off.
module seg7_decoder
  import score_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [7:0] seg
);

  // Look up the segment pattern, forcing all-off when blanked
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_display_driver.sv
// Score display driver: converts the 8-bit binary score to three BCD digits
// with a sequential double-dabble FSM, then time-multiplexes the digits onto
// a four-digit common-anode seven-segment display selected by STROBE.
// Digit 3 is permanently blank.
// Optional macro SCORE_DISP_BLANK_EN enables leading-zero blanking of the
// hundreds and tens digits; the ones digit is always shown.
module score_display_driver
  import score_disp_pkg::*;
#(
  parameter int SHIFT_STEPS = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] SCORE,
  input  logic [1:0] STROBE,
  output logic [3:0] SEG_SELECT,
  output logic [7:0] HEX_OUT,
  output logic       BUSY
);

  localparam logic [3:0] STEP_LAST = 4'(SHIFT_STEPS - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  last_score;
  logic [19:0] shreg;
  logic [19:0] shreg_adj;
  logic [3:0]  step;
  logic [3:0]  disp_h;
  logic [3:0]  disp_t;
  logic [3:0]  disp_o;
  logic [3:0]  mux_digit;
  logic        mux_blank;
  logic [3:0]  mux_anode;
  logic [7:0]  dec_seg;

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (SCORE != last_score) state_next = ST_SHIFT;
      ST_SHIFT: if (step == STEP_LAST)   state_next = ST_LATCH;
      ST_LATCH: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: busy for the whole shift and latch sequence
  always_comb begin
    BUSY = (state == ST_SHIFT) || (state == ST_LATCH);
  end

  // Nibble correction applied before each shift
  always_comb begin
    shreg_adj = {dd_adjust(shreg[19:16]), dd_adjust(shreg[15:12]),
                 dd_adjust(shreg[11:8]), shreg[7:0]};
  end

  // Conversion datapath: capture new score, shift, and latch finished digits
  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_score <= 8'd0;
      shreg      <= 20'd0;
      step       <= 4'd0;
      disp_h     <= 4'd0;
      disp_t     <= 4'd0;
      disp_o     <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (SCORE != last_score) begin
            shreg      <= {12'd0, SCORE};
            last_score <= SCORE;
            step       <= 4'd0;
          end
        end
        ST_SHIFT: begin
          shreg <= {shreg_adj[18:0], 1'b0};
          step  <= step + 4'd1;
        end
        ST_LATCH: begin
          disp_h <= shreg[19:16];
          disp_t <= shreg[15:12];
          disp_o <= shreg[11:8];
        end
        default: ;
      endcase
    end
  end

  // Digit mux: pick the digit, anode pattern and blanking for this strobe
  always_comb begin
    mux_digit = 4'd0;
    mux_blank = 1'b0;
    mux_anode = AN_NONE;
    case (STROBE)
      2'd0: begin
        mux_digit = disp_o;
        mux_anode = AN_DIG0;
      end
      2'd1: begin
        mux_digit = disp_t;
        mux_anode = AN_DIG1;
`ifdef SCORE_DISP_BLANK_EN
        mux_blank = (disp_h == 4'd0) && (disp_t == 4'd0);
`else
        mux_blank = 1'b0;
`endif
      end
      2'd2: begin
        mux_digit = disp_h;
        mux_anode = AN_DIG2;
`ifdef SCORE_DISP_BLANK_EN
        mux_blank = (disp_h == 4'd0);
`else
        mux_blank = 1'b0;
`endif
      end
      default: begin
        mux_digit = 4'd0;
        mux_blank = 1'b1;
        mux_anode = AN_DIG3;
      end
    endcase
  end

  seg7_decoder u_dec (
    .digit (mux_digit),
    .blank (mux_blank),
    .seg   (dec_seg)
  );

  // Register anode and segment lines together so they switch on one edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      SEG_SELECT <= AN_NONE;
      HEX_OUT    <= SEG_BLANK;
    end else begin
      SEG_SELECT <= mux_anode;
      HEX_OUT    <= dec_seg;
    end
  end

endmodule

// File: tb/tb_score_display_driver.sv
// Self-checking bench for score_display_driver: directed scenarios plus
// randomized scores checked against a decimal-arithmetic display model.
module tb_score_display_driver;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] SCORE;
  logic [1:0] STROBE;
  logic [3:0] SEG_SELECT;
  logic [7:0] HEX_OUT;
  logic       BUSY;

  int checks = 0;
  int failures = 0;
  int cur = 0;

`ifdef SCORE_DISP_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  localparam logic [7:0] SEG_TBL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  score_display_driver dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .SCORE      (SCORE),
    .STROBE     (STROBE),
    .SEG_SELECT (SEG_SELECT),
    .HEX_OUT    (HEX_OUT),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] exp_hex(input int sc, input int sb);
    int h, t, o;
    h = sc / 100;
    t = (sc / 10) % 10;
    o = sc % 10;
    case (sb)
      0: return SEG_TBL[o];
      1: return (BLANK && h == 0 && t == 0) ? 8'hFF : SEG_TBL[t];
      2: return (BLANK && h == 0) ? 8'hFF : SEG_TBL[h];
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [3:0] exp_sel(input int sb);
    logic [3:0] m;
    m = 4'b1111;
    m[sb] = 1'b0;
    return m;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Advance until the conversion finishes; reports whether it did in time
  task automatic wait_done(output bit ok);
    int n;
    tick();
    n = 0;
    while (BUSY && n < 40) begin
      tick();
      n++;
    end
    ok = !BUSY;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    SCORE = 8'd0;
    STROBE = 2'd0;
    tick();
    tick();
    checks++;
    if (BUSY !== 1'b0 || SEG_SELECT !== 4'b1111 || HEX_OUT !== 8'hFF) begin
      failures++;
      $display("FAIL reset busy=%b sel=%b hex=%h required busy=0 sel=1111 hex=ff",
               BUSY, SEG_SELECT, HEX_OUT);
    end
    RESET = 1'b0;
    cur = 0;
  endtask

  task automatic test_zero_mux();
    for (int s = 0; s < 4; s++) begin
      STROBE = 2'(s);
      tick();
      checks++;
      if (SEG_SELECT !== exp_sel(s) || HEX_OUT !== exp_hex(0, s) || BUSY !== 1'b0) begin
        failures++;
        $display("FAIL zero_mux s=%0d sel=%b hex=%h busy=%b required sel=%b hex=%h busy=0",
                 s, SEG_SELECT, HEX_OUT, BUSY, exp_sel(s), exp_hex(0, s));
      end
    end
  endtask

  task automatic test_latency_123();
    int busy_cycles;
    STROBE = 2'd0;
    SCORE = 8'd123;
    busy_cycles = 0;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (BUSY) busy_cycles++;
      if (c == 10) begin
        checks++;
        if (HEX_OUT !== 8'hC0) begin
          failures++;
          $display("FAIL latency_early hex=%h required c0", HEX_OUT);
        end
      end
      if (c == 11) begin
        checks++;
        if (HEX_OUT !== 8'hB0) begin
          failures++;
          $display("FAIL latency_ones hex=%h required b0", HEX_OUT);
        end
      end
    end
    checks++;
    if (busy_cycles != 9) begin
      failures++;
      $display("FAIL busy_len got=%0d required 9", busy_cycles);
    end
    STROBE = 2'd2;
    tick();
    checks++;
    if (HEX_OUT !== 8'hF9 || SEG_SELECT !== 4'b1011) begin
      failures++;
      $display("FAIL hundreds_123 hex=%h sel=%b required f9 1011", HEX_OUT, SEG_SELECT);
    end
    cur = 123;
  endtask

  task automatic test_wrap();
    bit ok;
    SCORE = 8'd255;
    wait_done(ok);
    cur = 255;
    STROBE = 2'd1;
    tick();
    checks++;
    if (!ok || HEX_OUT !== 8'h92) begin
      failures++;
      $display("FAIL wrap_255 done=%b hex=%h required done=1 hex=92", ok, HEX_OUT);
    end
    SCORE = 8'd0;
    repeat (10) tick();
    cur = 0;
    for (int s = 0; s < 3; s++) begin
      STROBE = 2'(s);
      tick();
      checks++;
      if (HEX_OUT !== exp_hex(0, s) || SEG_SELECT !== exp_sel(s)) begin
        failures++;
        $display("FAIL wrap_0 s=%0d hex=%h sel=%b required %h %b",
                 s, HEX_OUT, SEG_SELECT, exp_hex(0, s), exp_sel(s));
      end
    end
  endtask

  task automatic test_midchange();
    bit ok;
    SCORE = 8'd10;
    repeat (4) tick();
    SCORE = 8'd47;
    repeat (6) tick();
    checks++;
    if (BUSY !== 1'b0) begin
      failures++;
      $display("FAIL mid_first_done busy=%b required 0", BUSY);
    end
    STROBE = 2'd1;
    tick();
    checks++;
    if (HEX_OUT !== exp_hex(10, 1) || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL mid_first_value hex=%h busy=%b required hex=%h busy=1",
               HEX_OUT, BUSY, exp_hex(10, 1));
    end
    wait_done(ok);
    cur = 47;
    for (int s = 0; s < 4; s++) begin
      STROBE = 2'(s);
      tick();
      checks++;
      if (!ok || HEX_OUT !== exp_hex(47, s) || SEG_SELECT !== exp_sel(s)) begin
        failures++;
        $display("FAIL mid_second s=%0d done=%b hex=%h sel=%b required %h %b",
                 s, ok, HEX_OUT, SEG_SELECT, exp_hex(47, s), exp_sel(s));
      end
    end
  endtask

  task automatic test_reset_mid();
    SCORE = 8'd200;
    repeat (5) tick();
    RESET = 1'b1;
    tick();
    checks++;
    if (BUSY !== 1'b0 || SEG_SELECT !== 4'b1111 || HEX_OUT !== 8'hFF) begin
      failures++;
      $display("FAIL reset_mid busy=%b sel=%b hex=%h required busy=0 sel=1111 hex=ff",
               BUSY, SEG_SELECT, HEX_OUT);
    end
    RESET = 1'b0;
    SCORE = 8'd0;
    cur = 0;
    for (int s = 0; s < 4; s++) begin
      STROBE = 2'(s);
      tick();
      checks++;
      if (BUSY !== 1'b0 || HEX_OUT !== exp_hex(0, s) || SEG_SELECT !== exp_sel(s)) begin
        failures++;
        $display("FAIL reset_mid_digits s=%0d busy=%b hex=%h sel=%b required busy=0 %h %b",
                 s, BUSY, HEX_OUT, SEG_SELECT, exp_hex(0, s), exp_sel(s));
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int v;
    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(0, 255));
      if (v == cur) v = (v + 1) % 256;
      SCORE = 8'(v);
      wait_done(ok);
      cur = v;
      for (int s = 0; s < 4; s++) begin
        STROBE = 2'(s);
        tick();
        checks++;
        if (!ok || HEX_OUT !== exp_hex(v, s) || SEG_SELECT !== exp_sel(s)) begin
          failures++;
          $display("FAIL random score=%0d s=%0d done=%b hex=%h sel=%b required %h %b",
                   v, s, ok, HEX_OUT, SEG_SELECT, exp_hex(v, s), exp_sel(s));
        end
      end
    end
  endtask

  task automatic test_blank();
    bit ok;
    logic [7:0] got [3];
    SCORE = 8'd7;
    wait_done(ok);
    for (int s = 0; s < 3; s++) begin
      STROBE = 2'(s);
      tick();
      got[s] = HEX_OUT;
    end
    checks++;
    if (!ok || got[0] !== 8'hF8 || got[1] !== 8'hFF || got[2] !== 8'hFF) begin
      failures++;
      $display("FAIL blank_7 ones=%h tens=%h hund=%h required f8 ff ff",
               got[0], got[1], got[2]);
    end
    SCORE = 8'd105;
    wait_done(ok);
    for (int s = 0; s < 3; s++) begin
      STROBE = 2'(s);
      tick();
      got[s] = HEX_OUT;
    end
    cur = 105;
    checks++;
    if (!ok || got[0] !== 8'h92 || got[1] !== 8'hC0 || got[2] !== 8'hF9) begin
      failures++;
      $display("FAIL blank_105 ones=%h tens=%h hund=%h required 92 c0 f9",
               got[0], got[1], got[2]);
    end
  endtask

  initial begin
    test_reset();
    test_zero_mux();
    test_latency_123();
    test_wrap();
    test_midchange();
    test_reset_mid();
    test_random();
`ifdef SCORE_DISP_BLANK_EN
    test_blank();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
